fp_alu_unit: RTL and testbench

Single-precision IEEE 754 arithmetic/compare unit. It performs add or subtract on two 32-bit operands, or evaluates one of six relational predicates. The unit is pipelined and gated by a clock enable. It is the shared floating-point engine used by the CORDIC angle-reduction and output-conversion logic.

---
 rtl/fp_alu_pkg.sv | 33 +++
 rtl/fp_alu_unit_if.sv | 16 +
 rtl/fp_addsub_path.sv | 110 +++++++++++
 rtl/fp_alu_unit.sv | 110 +++++++++++
 tb/tb_fp_alu_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fp_alu_pkg.sv
// Shared opcode, field-width and special-value constants for the fp_alu_unit datapath.
// Pure declarations: no latency, no flow control.
package fp_alu_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int FP_W   = SIGN_W + EXP_W + MAN_W;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_LT  = 6'b001100;
    localparam logic [5:0] OP_EQ  = 6'b010100;
    localparam logic [5:0] OP_LE  = 6'b011100;
    localparam logic [5:0] OP_GT  = 6'b100100;
    localparam logic [5:0] OP_NE  = 6'b101100;
    localparam logic [5:0] OP_GE  = 6'b110100;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC00000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F800000;
    localparam logic [FP_W-1:0] NEG_INF = 32'hFF800000;

    // Leading-zero count of the 27-bit guarded mantissa; 27 when all zero.
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_alu_unit_if.sv
// Operand/opcode/result bundle between a client and fp_alu_unit.
// ce gates the whole pipeline; there is no other backpressure.
interface fp_alu_unit_if;
    import fp_alu_pkg::*;

    logic            ce;
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic [5:0]      operation;
    logic [FP_W-1:0] result;
    logic            rdy;

    modport master (output ce, a, b, operation, input result, rdy);
    modport slave  (input ce, a, b, operation, output result, rdy);

endinterface

// File: rtl/fp_addsub_path.sv
// Single-precision add/sub: align+add registered here, normalize+round combinational after.
// One register stage; advances only when ce=1, sclr clears it.
module fp_addsub_path
    import fp_alu_pkg::*;
(
    input  logic            clk,
    input  logic            sclr,
    input  logic            ce,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            sub,
    output logic [FP_W-1:0] res
);

    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, swap, big_s, small_s;
    logic [30:0]      ka, kb, big_k, small_k;
    logic [EXP_W-1:0] eb, es, d;
    logic [4:0]       dcap;
    logic [26:0]      mb, ms, ms_al;
    logic [58:0]      ext;
    logic [27:0]      sum;
    logic             nan_c, inf_c, inf_sign_c;

    always_comb begin
        sa    = a[31];
        sb    = b[31] ^ sub;
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        // Denormal inputs collapse to zero magnitude before alignment.
        ka = (a[30:23] == '0) ? 31'b0 : a[30:0];
        kb = (b[30:23] == '0) ? 31'b0 : b[30:0];
        swap    = kb > ka;
        big_k   = swap ? kb : ka;
        small_k = swap ? ka : kb;
        big_s   = swap ? sb : sa;
        small_s = swap ? sa : sb;
        eb = big_k[30:23];
        es = small_k[30:23];
        mb = {|eb, big_k[22:0], 3'b000};
        ms = {|es, small_k[22:0], 3'b000};
        d    = eb - es;
        dcap = (d > 8'd31) ? 5'd31 : d[4:0];
        ext  = {ms, 32'b0} >> dcap;
        ms_al = {ext[58:33], ext[32] | (|ext[31:0])};
        sum = (big_s != small_s) ? ({1'b0, mb} - {1'b0, ms_al})
                                 : ({1'b0, mb} + {1'b0, ms_al});
        nan_c      = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
        inf_c      = a_inf || b_inf;
        inf_sign_c = a_inf ? sa : sb;
    end

    logic             s2_nan, s2_inf, s2_inf_sign, s2_sign;
    logic [EXP_W-1:0] s2_exp;
    logic [27:0]      s2_sum;

    always_ff @(posedge clk) begin
        if (sclr) begin
            s2_nan      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_inf_sign <= 1'b0;
            s2_sign     <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
        end else if (ce) begin
            s2_nan      <= nan_c;
            s2_inf      <= inf_c;
            s2_inf_sign <= inf_sign_c;
            s2_sign     <= big_s;
            s2_exp      <= eb;
            s2_sum      <= sum;
        end
    end

    logic [4:0]        lz;
    logic [26:0]       m;
    logic signed [9:0] e, e_r;
    logic              rnd;
    logic [24:0]       mr;
    logic [MAN_W-1:0]  frac;

    always_comb begin
        lz = clz27(s2_sum[26:0]);
        if (s2_sum[27]) begin
            m = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
            e = $signed({2'b00, s2_exp}) + 10'sd1;
        end else begin
            m = s2_sum[26:0] << lz;
            e = $signed({2'b00, s2_exp}) - $signed({5'b00000, lz});
        end
        rnd = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[26:3]} + 25'(rnd);
        if (mr[24]) begin
            e_r  = e + 10'sd1;
            frac = mr[23:1];
        end else begin
            e_r  = e;
            frac = mr[22:0];
        end

        if (s2_nan)                 res = QNAN;
        else if (s2_inf)            res = s2_inf_sign ? NEG_INF : POS_INF;
        else if (s2_sum == '0)      res = '0;
        else if (e_r >= 10'sd255)   res = s2_sign ? NEG_INF : POS_INF;
        else if (e_r <= 10'sd0)     res = {s2_sign, 31'b0};
        else                        res = {s2_sign, e_r[7:0], frac};
    end

endmodule

// File: rtl/fp_alu_unit.sv
// IEEE 754 single add/sub/compare unit; LATENCY ce-qualified edges from capture to rdy.
// No backpressure: ce=0 freezes every stage, and result/rdy hold.
module fp_alu_unit
    import fp_alu_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic           clk,
    input  logic           sclr,
    fp_alu_unit_if.slave   bus
);

    logic [FP_W-1:0]    s1_a, s1_b;
    logic [5:0]         s1_op;
    logic [LATENCY-1:0] vld;

    always_ff @(posedge clk) begin
        if (sclr) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= OP_ADD;
            vld   <= '0;
        end else if (bus.ce) begin
            s1_a  <= bus.a;
            s1_b  <= bus.b;
            s1_op <= bus.operation;
            vld   <= {vld[LATENCY-2:0], 1'b1};
        end
    end

    logic [30:0] a_mag, b_mag;
    logic        a_nan, b_nan, both_zero, eq, lt, cmp_bit;

    always_comb begin
        a_mag     = (s1_a[30:23] == '0) ? 31'b0 : s1_a[30:0];
        b_mag     = (s1_b[30:23] == '0) ? 31'b0 : s1_b[30:0];
        a_nan     = (&s1_a[30:23]) && (|s1_a[22:0]);
        b_nan     = (&s1_b[30:23]) && (|s1_b[22:0]);
        both_zero = (a_mag == '0) && (b_mag == '0);
        eq        = both_zero || ((s1_a[31] == s1_b[31]) && (a_mag == b_mag));
        if (both_zero)                lt = 1'b0;
        else if (s1_a[31] != s1_b[31]) lt = s1_a[31];
        else if (s1_a[31])            lt = a_mag > b_mag;
        else                          lt = a_mag < b_mag;

        case (s1_op)
            OP_LT:   cmp_bit = lt;
            OP_EQ:   cmp_bit = eq;
            OP_LE:   cmp_bit = lt | eq;
            OP_GT:   cmp_bit = !(lt | eq);
            OP_NE:   cmp_bit = !eq;
            OP_GE:   cmp_bit = !lt;
            default: cmp_bit = 1'b0;
        endcase
        // Unordered operands: only notequal holds.
        if (a_nan || b_nan) cmp_bit = (s1_op == OP_NE);
    end

    logic [5:0]      s2_op;
    logic            s2_cmp;
    logic [FP_W-1:0] arith_res, stage2_res;

    always_ff @(posedge clk) begin
        if (sclr) begin
            s2_op  <= OP_ADD;
            s2_cmp <= 1'b0;
        end else if (bus.ce) begin
            s2_op  <= s1_op;
            s2_cmp <= cmp_bit;
        end
    end

    fp_addsub_path u_addsub (
        .clk  (clk),
        .sclr (sclr),
        .ce   (bus.ce),
        .a    (s1_a),
        .b    (s1_b),
        .sub  (s1_op == OP_SUB),
        .res  (arith_res)
    );

    always_comb begin
        case (s2_op)
            OP_ADD, OP_SUB:                            stage2_res = arith_res;
            OP_LT, OP_EQ, OP_LE, OP_GT, OP_NE, OP_GE:  stage2_res = {31'b0, s2_cmp};
            default:                                   stage2_res = '0;
        endcase
    end

    generate
        if (LATENCY == 2) begin : g_direct
            assign bus.result = stage2_res;
        end else begin : g_delay
            logic [FP_W-1:0] dly [LATENCY-2];
            always_ff @(posedge clk) begin
                if (sclr) begin
                    for (int i = 0; i < LATENCY - 2; i++) dly[i] <= '0;
                end else if (bus.ce) begin
                    dly[0] <= stage2_res;
                    for (int i = 1; i < LATENCY - 2; i++) dly[i] <= dly[i-1];
                end
            end
            assign bus.result = dly[LATENCY-3];
        end
    endgenerate

    assign bus.rdy = vld[LATENCY-1];

endmodule

// File: tb/tb_fp_alu_unit.sv
// Directed-vector bench for fp_alu_unit: arithmetic, compare, hold, reset and streaming.
module tb_fp_alu_unit;
    import fp_alu_pkg::*;

    localparam int LAT = 3;
    localparam int NV  = 24;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    fp_alu_unit_if bus ();

    fp_alu_unit #(.LATENCY(LAT)) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    vec_t vecs [NV] = '{
        '{32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000},
        '{32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000},
        '{32'h40400000, 32'h3F000000, OP_SUB, 32'h40200000},
        '{32'h3F800000, 32'h00000000, OP_GT,  32'h00000001},
        '{32'h3F800000, 32'h00000000, OP_LT,  32'h00000000},
        '{32'h3F800000, 32'h3F800000, OP_GE,  32'h00000001},
        '{32'h00000000, 32'h80000000, OP_EQ,  32'h00000001},
        '{32'h7FC00000, 32'h00000000, OP_GE,  32'h00000000},
        '{32'h7FC00000, 32'h00000000, OP_NE,  32'h00000001},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, 32'h7F800000},
        '{32'h7F800000, 32'h7F800000, OP_SUB, 32'h7FC00000},
        '{32'h3F800000, 32'h33800000, OP_ADD, 32'h3F800000},
        '{32'h3F800001, 32'h33800000, OP_ADD, 32'h3F800002},
        '{32'h00000001, 32'h3F800000, OP_ADD, 32'h3F800000},
        '{32'h80800001, 32'h80800000, OP_SUB, 32'h80000000},
        '{32'hFF800000, 32'h7F800000, OP_LT,  32'h00000001},
        '{32'hC0000000, 32'hBF800000, OP_LT,  32'h00000001},
        '{32'h00400000, 32'h80000000, OP_LE,  32'h00000001},
        '{32'h3F800000, 32'h40000000, 6'b111111, 32'h00000000},
        '{32'h7F800000, 32'h3F800000, OP_ADD, 32'h7F800000},
        '{32'hFF800000, 32'h7F800000, OP_ADD, 32'h7FC00000},
        '{32'h7FC00000, 32'h7FC00000, OP_EQ,  32'h00000000},
        '{32'hC0000000, 32'h3F800000, OP_ADD, 32'hBF800000},
        '{32'h7F800001, 32'h3F800000, OP_ADD, 32'h7FC00000}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sclr   = 1'b1;
        bus.ce = 1'b0;
        tick();
        sclr   = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [5:0] op, input logic [31:0] want);
        do_reset();
        bus.a = av;
        bus.b = bv;
        bus.operation = op;
        bus.ce = 1'b1;
        repeat (LAT - 1) tick();
        check({tag, "_rdy_early"}, {31'b0, bus.rdy}, 32'd0);
        tick();
        bus.ce = 1'b0;
        check({tag, "_rdy"}, {31'b0, bus.rdy}, 32'd1);
        check({tag, "_res"}, bus.result, want);
    endtask

    initial begin
        sclr = 1'b1;
        bus.ce = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.operation = OP_ADD;
        tick();
        tick();
        sclr = 1'b0;
        check("reset_res", bus.result, 32'd0);
        check("reset_rdy", {31'b0, bus.rdy}, 32'd0);

        for (int i = 0; i < NV; i++)
            run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);

        // Hold with ce low while the inputs wander.
        run_op("hold_setup", 32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000);
        bus.a = 32'h40000000;
        bus.operation = OP_SUB;
        repeat (5) tick();
        check("hold_res", bus.result, 32'h40400000);
        check("hold_rdy", {31'b0, bus.rdy}, 32'd1);

        // One ce edge, then a stall: rdy needs two further ce edges.
        do_reset();
        bus.a = 32'h3F800000;
        bus.b = 32'h40000000;
        bus.operation = OP_ADD;
        bus.ce = 1'b1;
        tick();
        bus.ce = 1'b0;
        bus.a = 32'h40000000;
        bus.b = 32'h40000000;
        repeat (4) tick();
        check("stall_rdy_frozen", {31'b0, bus.rdy}, 32'd0);
        bus.ce = 1'b1;
        tick();
        check("stall_rdy_one_more", {31'b0, bus.rdy}, 32'd0);
        tick();
        check("stall_rdy", {31'b0, bus.rdy}, 32'd1);
        check("stall_res", bus.result, 32'h40400000);

        // Synchronous clear wins over ce in the middle of a stream.
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("sclr_res", bus.result, 32'd0);
        check("sclr_rdy", {31'b0, bus.rdy}, 32'd0);

        // Back-to-back stream: one result per edge, in order.
        do_reset();
        bus.ce = 1'b1;
        for (int i = 0; i < NV + LAT - 1; i++) begin
            if (i < NV) begin
                bus.a = vecs[i].a;
                bus.b = vecs[i].b;
                bus.operation = vecs[i].op;
            end
            tick();
            if (i >= LAT - 1) begin
                check($sformatf("stream%0d_rdy", i - LAT + 1), {31'b0, bus.rdy}, 32'd1);
                check($sformatf("stream%0d_res", i - LAT + 1), bus.result, vecs[i - LAT + 1].exp);
            end else begin
                check($sformatf("stream_fill%0d_rdy", i), {31'b0, bus.rdy}, 32'd0);
            end
        end
        bus.ce = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
